// File: rtl/yin_pkg.sv
// -----------------------------------------------------------------------------
// yin_pkg
// Shared definitions for the YIN lag-sweep scheduler slice.
//   TAU_W       : width of every lag (tau) bus
//   WINDOW_LEN  : window length for the default WINDOW_SIZE_BITS
//   window_len(): window length for an arbitrary WINDOW_SIZE_BITS
//   state_t     : scheduler FSM states
// -----------------------------------------------------------------------------
package yin_pkg;

    localparam int unsigned TAU_W                    = 6;
    localparam int unsigned WINDOW_SIZE_BITS_DEFAULT = 8;
    localparam int unsigned WINDOW_LEN               = 2 ** WINDOW_SIZE_BITS_DEFAULT;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic int unsigned window_len(input int unsigned bits);
        return 32'd1 << bits;
    endfunction

endpackage

// File: rtl/yin_tau_scheduler_min_tracker.sv
// -----------------------------------------------------------------------------
// yin_min_tracker
// Running minimum of d(tau) over one sweep.
//   i_clk        : system clock
//   i_reset      : synchronous active-high reset
//   i_clear      : start of a new sweep, forget the previous minimum
//   i_update     : offer (i_tau, i_value) as a candidate this cycle
//   o_best_tau   : lag of the smallest value seen so far
//   o_best_value : smallest value seen so far (all-ones when empty)
// Strict less-than: lags arrive in increasing order, so an equal value never
// displaces the earlier (smaller) lag.
// -----------------------------------------------------------------------------
module yin_min_tracker
    import yin_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_update,
    input  logic [TAU_W-1:0]  i_tau,
    input  logic [DATA_W-1:0] i_value,
    output logic [TAU_W-1:0]  o_best_tau,
    output logic [DATA_W-1:0] o_best_value
);

    logic [TAU_W-1:0]  r_best_tau;
    logic [DATA_W-1:0] r_best_value;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_best_tau   <= '0;
            r_best_value <= '1;
        end else if (i_update && (i_value < r_best_value)) begin
            r_best_tau   <= i_tau;
            r_best_value <= i_value;
        end
    end

    assign o_best_tau   = r_best_tau;
    assign o_best_value = r_best_value;

endmodule

// File: rtl/yin_tau_scheduler.sv
// -----------------------------------------------------------------------------
// yin_tau_scheduler
// Sweeps the diff_module datapath over tau = TAU_MIN..MAX_TAU for one frame,
// streams each d(tau) and reports the minimum.
//   clk, reset        : clock, synchronous active-high reset
//   start, abort      : begin sweep (IDLE/DONE only), cancel sweep
//   busy, frame_lock  : sweep in progress / upstream must hold data_in
//   diff_reset        : clears diff_module
//   diff_tau          : lag presented to diff_module
//   diff_ready        : diff_module result available
//   diff_accumulator  : diff_module result
//   d_valid/d_tau/d_value       : one pulse per captured lag
//   done                         : one pulse at sweep end (normal or watchdog)
//   result_valid/best_tau/best_value : minimum over the sweep
//   error                        : sticky watchdog flag
// Timing per lag: CLEAR 1 cycle, RUN until diff_ready, CAPTURE 1 cycle.
// -----------------------------------------------------------------------------
module yin_tau_scheduler
    import yin_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE_BITS        = 8,
    parameter int unsigned INTERMEDIATE_DATA_WIDTH = 64,
    parameter int unsigned TAU_MIN                 = 1,
    parameter int unsigned MAX_TAU                 = 40,
    parameter int unsigned WATCHDOG_CYCLES         = (2 ** WINDOW_SIZE_BITS) + 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    output logic                               busy,
    output logic                               frame_lock,
    output logic                               diff_reset,
    output logic [TAU_W-1:0]                   diff_tau,
    input  logic                               diff_ready,
    input  logic [INTERMEDIATE_DATA_WIDTH-1:0] diff_accumulator,
    output logic                               d_valid,
    output logic [TAU_W-1:0]                   d_tau,
    output logic [INTERMEDIATE_DATA_WIDTH-1:0] d_value,
    output logic                               done,
    output logic                               result_valid,
    output logic [TAU_W-1:0]                   best_tau,
    output logic [INTERMEDIATE_DATA_WIDTH-1:0] best_value,
    output logic                               error
);

    localparam int unsigned DW          = INTERMEDIATE_DATA_WIDTH;
    localparam int unsigned RUN_CYCLES  = window_len(WINDOW_SIZE_BITS) + 1;
    localparam int unsigned WD_W        = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [TAU_W-1:0] TAU_FIRST = TAU_W'(TAU_MIN);
    localparam logic [TAU_W-1:0] TAU_LAST  = TAU_W'(MAX_TAU);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WATCHDOG_CYCLES - 1);

    if (TAU_MIN < 1) begin : g_bad_tau_min
        $error("TAU_MIN must be at least 1");
    end
    if (MAX_TAU > 63 || MAX_TAU < TAU_MIN) begin : g_bad_max_tau
        $error("MAX_TAU must lie in TAU_MIN..63");
    end
    if (WATCHDOG_CYCLES <= RUN_CYCLES) begin : g_bad_watchdog
        $error("WATCHDOG_CYCLES must exceed the normal RUN length");
    end

    state_t            r_state;
    logic              r_busy;
    logic              r_diff_reset;
    logic [TAU_W-1:0]  r_diff_tau;
    logic [WD_W-1:0]   r_wd;
    logic              r_d_valid;
    logic [TAU_W-1:0]  r_d_tau;
    logic [DW-1:0]     r_d_value;
    logic              r_done;
    logic              r_result_valid;
    logic              r_error;

    logic              w_start_acc;
    logic              w_update;

    // abort outranks start in every state, including the tracker controls
    assign w_start_acc = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_update    = !abort && (r_state == ST_CAPTURE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_diff_reset   <= 1'b1;
            r_diff_tau     <= TAU_FIRST;
            r_wd           <= '0;
            r_d_valid      <= 1'b0;
            r_d_tau        <= '0;
            r_d_value      <= '0;
            r_done         <= 1'b0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_d_valid <= 1'b0;
            r_done    <= 1'b0;
            if (abort) begin
                r_state        <= ST_IDLE;
                r_busy         <= 1'b0;
                r_diff_reset   <= 1'b1;
                r_result_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        r_diff_reset <= 1'b1;
                        if (w_start_acc) begin
                            r_state        <= ST_CLEAR;
                            r_busy         <= 1'b1;
                            r_diff_tau     <= TAU_FIRST;
                            r_result_valid <= 1'b0;
                            r_error        <= 1'b0;
                        end
                    end
                    ST_CLEAR: begin
                        r_state      <= ST_RUN;
                        r_diff_reset <= 1'b0;
                        r_wd         <= '0;
                    end
                    ST_RUN: begin
                        if (diff_ready) begin
                            r_state      <= ST_CAPTURE;
                            r_d_valid    <= 1'b1;
                            r_d_tau      <= r_diff_tau;
                            r_d_value    <= diff_accumulator;
                            // datapath result is latched, so clear it early
                            r_diff_reset <= 1'b1;
                        end else if (r_wd == WD_LAST) begin
                            r_state        <= ST_DONE;
                            r_busy         <= 1'b0;
                            r_diff_reset   <= 1'b1;
                            r_done         <= 1'b1;
                            r_result_valid <= 1'b0;
                            r_error        <= 1'b1;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        r_diff_reset <= 1'b1;
                        if (r_diff_tau == TAU_LAST) begin
                            r_state        <= ST_DONE;
                            r_busy         <= 1'b0;
                            r_done         <= 1'b1;
                            r_result_valid <= 1'b1;
                        end else begin
                            r_state    <= ST_CLEAR;
                            r_diff_tau <= r_diff_tau + 1'b1;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_diff_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

    yin_min_tracker #(
        .DATA_W (DW)
    ) u_min_tracker (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_clear      (w_start_acc),
        .i_update     (w_update),
        .i_tau        (r_d_tau),
        .i_value      (r_d_value),
        .o_best_tau   (best_tau),
        .o_best_value (best_value)
    );

    assign busy         = r_busy;
    assign frame_lock   = r_busy;
    assign diff_reset   = r_diff_reset;
    assign diff_tau     = r_diff_tau;
    assign d_valid      = r_d_valid;
    assign d_tau        = r_d_tau;
    assign d_value      = r_d_value;
    assign done         = r_done;
    assign result_valid = r_result_valid;
    assign error        = r_error;

endmodule

// File: tb/tb_yin_tau_scheduler.sv
// -----------------------------------------------------------------------------
// tb_yin_tau_scheduler
// Drives yin_tau_scheduler with a small difference-function stub and checks
// every cycle against a timeline model of the sweep.
// -----------------------------------------------------------------------------
module tb_yin_tau_scheduler;

    localparam int W    = 4;
    localparam int L    = 16;
    localparam int TMIN = 1;
    localparam int TMAX = 8;
    localparam int WD   = 32;
    localparam int PER  = L + 3;
    localparam int NT   = TMAX - TMIN + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, frame_lock, diff_reset, diff_ready;
    logic [5:0]  diff_tau, d_tau, best_tau;
    logic [63:0] diff_accumulator, d_value, best_value;
    logic        d_valid, done, result_valid, error;

    always #5 clk = ~clk;

    yin_tau_scheduler #(
        .WINDOW_SIZE_BITS        (W),
        .INTERMEDIATE_DATA_WIDTH (64),
        .TAU_MIN                 (TMIN),
        .MAX_TAU                 (TMAX),
        .WATCHDOG_CYCLES         (WD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .busy             (busy),
        .frame_lock       (frame_lock),
        .diff_reset       (diff_reset),
        .diff_tau         (diff_tau),
        .diff_ready       (diff_ready),
        .diff_accumulator (diff_accumulator),
        .d_valid          (d_valid),
        .d_tau            (d_tau),
        .d_value          (d_value),
        .done             (done),
        .result_valid     (result_valid),
        .best_tau         (best_tau),
        .best_value       (best_value),
        .error            (error)
    );

    // ---------------- difference-function stub ----------------
    int          x [0:31];
    bit          dead = 1'b0;
    logic [63:0] s_acc = '0;
    int          s_cnt = 0;
    logic        s_ready = 1'b0;

    function automatic longint sqd(input int a, input int b);
        longint df;
        df = longint'(a) - longint'(b);
        return df * df;
    endfunction

    always @(posedge clk) begin
        if (diff_reset === 1'b1) begin
            s_cnt   <= 0;
            s_acc   <= '0;
            s_ready <= 1'b0;
        end else if (s_ready === 1'b0) begin
            s_acc <= s_acc + 64'(sqd(x[s_cnt], x[s_cnt + int'(diff_tau)]));
            s_cnt <= s_cnt + 1;
            if (s_cnt == L - 1) s_ready <= 1'b1;
        end
    end

    assign diff_ready       = s_ready & ~dead;
    assign diff_accumulator = s_acc;

    // ---------------- reference model ----------------
    function automatic longint unsigned dval(input int tau);
        longint unsigned s = 0;
        for (int j = 0; j < L; j++) s += longint'(sqd(x[j], x[j + tau]));
        return s;
    endfunction

    bit          m_act, m_rv, m_err, m_done, m_dv, m_known;
    int          m_t;
    int          m_dtau, m_bt, m_cap_tau;
    logic [63:0] m_bv, m_cap_val;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          tick_no = 0;
    int          t_acc = 0;
    int          dv_cnt = 0;
    logic [63:0] seen_d [0:63];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @tick %0d: got %0d expected %0d", name, tick_no, got, exp);
        end
    endtask

    task automatic model_step();
        int tau;
        m_done = 1'b0;
        m_dv   = 1'b0;
        if (reset) begin
            m_act = 0; m_rv = 0; m_err = 0; m_bt = 0; m_bv = '1; m_known = 1; m_dtau = TMIN;
        end else if (abort) begin
            if (m_act) m_known = 0;
            m_act = 0;
            m_rv  = 0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1; m_t = 0; m_rv = 0; m_err = 0; m_bt = 0; m_bv = '1; m_known = 1;
                m_dtau = TMIN;
            end
        end else begin
            m_t++;
            if (dead) begin
                if (m_t == 1 + WD) begin
                    m_act = 0; m_done = 1; m_err = 1; m_rv = 0;
                end
            end else begin
                if (m_t % PER == 0) begin
                    tau = TMIN + m_t / PER - 1;
                    if (dval(tau) < m_bv) begin
                        m_bv = dval(tau);
                        m_bt = tau;
                    end
                end
                if (m_t == NT * PER) begin
                    m_act = 0; m_done = 1; m_rv = 1;
                end else begin
                    m_dtau = TMIN + m_t / PER;
                    if (m_t % PER == PER - 1) begin
                        m_dv      = 1;
                        m_cap_tau = m_dtau;
                        m_cap_val = dval(m_dtau);
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk("busy", 64'(busy), 64'(m_act));
        chk("frame_lock", 64'(frame_lock), 64'(m_act));
        chk("done", 64'(done), 64'(m_done));
        chk("error", 64'(error), 64'(m_err));
        chk("result_valid", 64'(result_valid), 64'(m_rv));
        chk("d_valid", 64'(d_valid), 64'(m_dv));
        chk("diff_tau", 64'(diff_tau), 64'(m_dtau));
        if (m_dv) begin
            chk("d_tau", 64'(d_tau), 64'(m_cap_tau));
            chk("d_value", d_value, m_cap_val);
        end
        if (!m_act) chk("diff_reset_idle", 64'(diff_reset), 64'd1);
        else if (dead) chk("diff_reset_run", 64'(diff_reset), 64'(m_t == 0));
        else if (m_t % PER != PER - 1) chk("diff_reset_run", 64'(diff_reset), 64'(m_t % PER == 0));
        if (m_known) begin
            chk("best_tau", 64'(best_tau), 64'(m_bt));
            chk("best_value", best_value, m_bv);
        end
        if (d_valid === 1'b1) begin
            dv_cnt++;
            seen_d[d_tau] = d_value;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        tick_no++;
        compare();
    endtask

    task automatic start_sweep();
        dv_cnt = 0;
        for (int i = 0; i < 64; i++) seen_d[i] = 'x;
        start = 1'b1;
        tick();
        start = 1'b0;
        t_acc = tick_no;
    endtask

    task automatic run_until_done(input int bound);
        int n;
        n = 0;
        while (n < bound && done !== 1'b1) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", bound);
        end
    endtask

    task automatic run_until_tau(input int tau, input bit need_run, input int bound);
        int n;
        n = 0;
        while (n < bound && !(diff_tau == 6'(tau) && (!need_run || diff_reset == 1'b0))) begin
            tick();
            n++;
        end
        if (!(diff_tau == 6'(tau) && (!need_run || diff_reset == 1'b0))) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tau_timeout: diff_tau %0d not reached within %0d cycles", tau, bound);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) x[i] = (i % 5) * 100;

        // reset
        reset = 1'b1;
        tick();
        tick();
        chk("reset_d_tau", 64'(d_tau), 64'd0);
        chk("reset_d_value", d_value, 64'd0);
        chk("reset_best_value", best_value, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("reset_diff_tau", 64'(diff_tau), 64'd1);
        reset = 1'b0;
        tick();

        // period-5 data
        start_sweep();
        run_until_done(400);
        chk("p5_latency", 64'(tick_no - t_acc), 64'd152);
        chk("p5_best_tau", 64'(best_tau), 64'd5);
        chk("p5_best_value", best_value, 64'd0);
        chk("p5_result_valid", 64'(result_valid), 64'd1);
        chk("p5_d1", seen_d[1], 64'd610000);
        chk("p5_d5", seen_d[5], 64'd0);
        chk("p5_dvalid_count", 64'(dv_cnt), 64'd8);
        tick();

        // constant data: every lag ties at zero
        for (int i = 0; i < 32; i++) x[i] = 1234;
        start_sweep();
        run_until_done(400);
        chk("const_latency", 64'(tick_no - t_acc), 64'd152);
        chk("const_best_tau", 64'(best_tau), 64'd1);
        chk("const_best_value", best_value, 64'd0);

        // start in the DONE cycle, then an ignored start at tau=4
        start_sweep();
        chk("restart_result_valid", 64'(result_valid), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        run_until_tau(4, 1'b0, 200);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(400);
        chk("midstart_latency", 64'(tick_no - t_acc), 64'd152);
        chk("midstart_best_tau", 64'(best_tau), 64'd1);
        tick();

        // datapath never ready: watchdog
        dead = 1'b1;
        start_sweep();
        run_until_done(100);
        chk("wd_latency", 64'(tick_no - t_acc), 64'd33);
        chk("wd_error", 64'(error), 64'd1);
        chk("wd_result_valid", 64'(result_valid), 64'd0);
        chk("wd_dvalid_count", 64'(dv_cnt), 64'd0);
        dead = 1'b0;
        tick();

        // reset during RUN at tau=3, then a clean sweep
        for (int i = 0; i < 32; i++) x[i] = (i % 5) * 100;
        start_sweep();
        run_until_tau(3, 1'b1, 200);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_diff_reset", 64'(diff_reset), 64'd1);
        chk("rst_best_value", best_value, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        start_sweep();
        run_until_done(400);
        chk("rst_sweep_best_tau", 64'(best_tau), 64'd5);
        chk("rst_sweep_latency", 64'(tick_no - t_acc), 64'd152);
        tick();

        // abort during the tau=6 capture
        start_sweep();
        begin
            int n;
            n = 0;
            while (n < 200 && !(d_valid === 1'b1 && d_tau == 6'd6)) begin
                tick();
                n++;
            end
            chk("abort_reached_capture", 64'(d_valid === 1'b1 && d_tau == 6'd6), 64'd1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_frame_lock", 64'(frame_lock), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        for (int i = 0; i < 30; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
